// File: rtl/host_loader_if.sv
// rtl/host_loader_if.sv - source-memory and uart bus bundle for host_loader
//
// Purpose: groups the source memory read bus and the uart_tx/uart_rx
//          handshake signals used by host_loader.
// Signals:
//   src_addr  [15:0]  source memory word address        (loader -> memory)
//   src_rd            one-cycle source read request      (loader -> memory)
//   src_data  [31:0]  source read data                   (memory -> loader)
//   src_valid         qualifies src_data                 (memory -> loader)
//   tx_data   [7:0]   byte to uart_tx                    (loader -> uart_tx)
//   tx_start          uart_tx start request              (loader -> uart_tx)
//   tx_busy           uart_tx busy                       (uart_tx -> loader)
//   rx_data   [7:0]   byte from uart_rx                  (uart_rx -> loader)
//   rx_ready          uart_rx data-ready level           (uart_rx -> loader)
// Modports: master = loader side, slave = memory/uart side.

interface host_loader_if;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [31:0] src_data;
  logic        src_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_ready;

  modport master (
    output src_addr, src_rd, tx_data, tx_start,
    input  src_data, src_valid, tx_busy, rx_data, rx_ready
  );

  modport slave (
    input  src_addr, src_rd, tx_data, tx_start,
    output src_data, src_valid, tx_busy, rx_data, rx_ready
  );
endinterface

// File: rtl/host_loader.sv
// rtl/host_loader.sv - serial program/sld loader and result receiver
//
// Purpose: waits for 0x99 from the core, sends a length header and the
//          program words, waits for 0xAA, sends the sld words, then
//          collects out_bytes result bytes.
// Optional feature: define HOST_LOADER_TIMEOUT_EN to enable the
//          handshake watchdog (TIMEOUT_CYCLES); otherwise waits are
//          unbounded and error is tied 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle session start pulse
//   prog_words, sld_base, sld_words, out_bytes   session config, sampled on start
//   bus                 host_loader_if.master (source memory + uart handshakes)
//   out_byte, out_valid received result byte and its one-cycle strobe
//   busy, done, error   session status (done/error sticky until rst)

module host_loader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         prog_words,
  input  logic [15:0]         sld_base,
  input  logic [15:0]         sld_words,
  input  logic [31:0]         out_bytes,
  host_loader_if.master       bus,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [3:0] {
    IDLE, WAIT99, HDR, PROG, WAITAA, SLD, RECV, DONE, ERROR
  } state_t;

  // Sub-phase used while a word is being fetched and/or transmitted.
  typedef enum logic [1:0] {
    PH_WV,      // src_rd issued, waiting for src_valid
    PH_TXREQ,   // tx_start held high, waiting for tx_busy=1
    PH_TXBUSY   // tx_start dropped, waiting for tx_busy=0
  } phase_t;

  state_t      state_q;
  phase_t      ph_q;
  logic [31:0] word_q;
  logic [1:0]  byte_idx_q;
  logic [15:0] idx_q;
  logic [31:0] rcnt_q;
  logic [15:0] prog_words_q;
  logic [15:0] sld_base_q;
  logic [15:0] sld_words_q;
  logic [31:0] out_bytes_q;
  logic        rx_seen_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        src_rd_q;
  logic [15:0] src_addr_q;
  logic [7:0]  out_byte_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        done_q;

  // A byte is taken only on the first cycle of an rx_ready high level.
  logic rx_fire;
  assign rx_fire = bus.rx_ready & ~rx_seen_q;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

`ifdef HOST_LOADER_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        error_q;
  logic        tmo_active;
  logic        progress;
  logic        in_xfer;

  assign in_xfer    = (state_q == HDR) || (state_q == PROG) || (state_q == SLD);
  assign tmo_active = (state_q == WAIT99) || (state_q == WAITAA) ||
                      (state_q == RECV) || in_xfer;
  // Anything that moves the session forward restarts the watchdog.
  assign progress = ((state_q == WAIT99) && rx_fire && (bus.rx_data == 8'h99)) ||
                    ((state_q == WAITAA) && rx_fire && (bus.rx_data == 8'haa)) ||
                    ((state_q == RECV) && rx_fire) ||
                    (in_xfer && (((ph_q == PH_WV) && bus.src_valid) ||
                                 ((ph_q == PH_TXREQ) && bus.tx_busy) ||
                                 ((ph_q == PH_TXBUSY) && !bus.tx_busy)));
  assign error = error_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ph_q         <= PH_WV;
      word_q       <= 32'd0;
      byte_idx_q   <= 2'd0;
      idx_q        <= 16'd0;
      rcnt_q       <= 32'd0;
      prog_words_q <= 16'd0;
      sld_base_q   <= 16'd0;
      sld_words_q  <= 16'd0;
      out_bytes_q  <= 32'd0;
      rx_seen_q    <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      src_rd_q     <= 1'b0;
      src_addr_q   <= 16'd0;
      out_byte_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef HOST_LOADER_TIMEOUT_EN
      tmo_q        <= 32'd0;
      error_q      <= 1'b0;
`endif
    end else begin
      rx_seen_q   <= bus.rx_ready;
      out_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            prog_words_q <= prog_words;
            sld_base_q   <= sld_base;
            sld_words_q  <= sld_words;
            out_bytes_q  <= out_bytes;
            busy_q       <= 1'b1;
            state_q      <= WAIT99;
          end
        end

        WAIT99: begin
          if (rx_fire && (bus.rx_data == 8'h99)) begin
            state_q    <= HDR;
            word_q     <= {14'd0, prog_words_q, 2'b00};
            byte_idx_q <= 2'd0;
            tx_data_q  <= {prog_words_q[5:0], 2'b00};
            tx_start_q <= 1'b1;
            ph_q       <= PH_TXREQ;
          end
        end

        HDR, PROG, SLD: begin
          case (ph_q)
            PH_WV: begin
              src_rd_q <= 1'b0;
              if (bus.src_valid) begin
                word_q     <= bus.src_data;
                byte_idx_q <= 2'd0;
                tx_data_q  <= bus.src_data[7:0];
                tx_start_q <= 1'b1;
                ph_q       <= PH_TXREQ;
              end
            end

            PH_TXREQ: begin
              if (bus.tx_busy) begin
                tx_start_q <= 1'b0;
                ph_q       <= PH_TXBUSY;
              end
            end

            default: begin
              if (!bus.tx_busy) begin
                if (byte_idx_q != 2'd3) begin
                  byte_idx_q <= byte_idx_q + 2'd1;
                  tx_data_q  <= byte_of(word_q, byte_idx_q + 2'd1);
                  tx_start_q <= 1'b1;
                  ph_q       <= PH_TXREQ;
                end else if (state_q == HDR) begin
                  if (prog_words_q == 16'd0) begin
                    state_q <= WAITAA;
                  end else begin
                    state_q    <= PROG;
                    idx_q      <= 16'd0;
                    src_addr_q <= 16'd0;
                    src_rd_q   <= 1'b1;
                    ph_q       <= PH_WV;
                  end
                end else if (state_q == PROG) begin
                  if (idx_q + 16'd1 == prog_words_q) begin
                    state_q <= WAITAA;
                  end else begin
                    idx_q      <= idx_q + 16'd1;
                    src_addr_q <= idx_q + 16'd1;
                    src_rd_q   <= 1'b1;
                    ph_q       <= PH_WV;
                  end
                end else begin
                  if (idx_q + 16'd1 == sld_words_q) begin
                    if (out_bytes_q == 32'd0) begin
                      state_q <= DONE;
                      done_q  <= 1'b1;
                      busy_q  <= 1'b0;
                    end else begin
                      state_q <= RECV;
                      rcnt_q  <= 32'd0;
                    end
                  end else begin
                    idx_q      <= idx_q + 16'd1;
                    src_addr_q <= sld_base_q + idx_q + 16'd1;
                    src_rd_q   <= 1'b1;
                    ph_q       <= PH_WV;
                  end
                end
              end
            end
          endcase
        end

        WAITAA: begin
          if (rx_fire && (bus.rx_data == 8'haa)) begin
            if (sld_words_q != 16'd0) begin
              state_q    <= SLD;
              idx_q      <= 16'd0;
              src_addr_q <= sld_base_q;
              src_rd_q   <= 1'b1;
              ph_q       <= PH_WV;
            end else if (out_bytes_q == 32'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RECV;
              rcnt_q  <= 32'd0;
            end
          end
        end

        RECV: begin
          if (rx_fire) begin
            out_byte_q  <= bus.rx_data;
            out_valid_q <= 1'b1;
            rcnt_q      <= rcnt_q + 32'd1;
            if (rcnt_q + 32'd1 == out_bytes_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end

        default: ;  // DONE / ERROR hold until rst
      endcase

`ifdef HOST_LOADER_TIMEOUT_EN
      // Placed after the case so a watchdog expiry overrides that cycle's move.
      if (tmo_active) begin
        if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          state_q    <= ERROR;
          error_q    <= 1'b1;
          busy_q     <= 1'b0;
          tx_start_q <= 1'b0;
          src_rd_q   <= 1'b0;
          tmo_q      <= 32'd0;
        end else if (progress) begin
          tmo_q <= 32'd0;
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end else begin
        tmo_q <= 32'd0;
      end
`endif
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.src_rd   = src_rd_q;
  assign bus.src_addr = src_addr_q;
  assign out_byte     = out_byte_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_host_loader.sv
// tb/tb_host_loader.sv - directed self-checking bench for host_loader

module tb_host_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] prog_words = 16'd0;
  logic [15:0] sld_base = 16'd0;
  logic [15:0] sld_words = 16'd0;
  logic [31:0] out_bytes = 32'd0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_q[$];
  logic [15:0] rd_log[$];
  logic [7:0]  out_q[$];
  int          busy_cnt;

  host_loader_if bus_if ();

  host_loader #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_words (prog_words),
    .sld_base   (sld_base),
    .sld_words  (sld_words),
    .out_bytes  (out_bytes),
    .bus        (bus_if),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 32'h00A00093;
      16'h0001: mem_word = 32'hFFFFFFFF;
      16'h0100: mem_word = 32'h11223344;
      16'h0101: mem_word = 32'hA5B6C7D8;
      default:  mem_word = 32'hDEADBEEF;
    endcase
  endfunction

  // Source memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      bus_if.src_valid <= 1'b0;
      bus_if.src_data  <= 32'd0;
    end else begin
      bus_if.src_valid <= 1'b0;
      if (bus_if.src_rd) begin
        bus_if.src_valid <= 1'b1;
        bus_if.src_data  <= mem_word(bus_if.src_addr);
        rd_log.push_back(bus_if.src_addr);
      end
    end
  end

  // uart_tx: accepts on tx_start while idle, stays busy for four cycles.
  always @(posedge clk) begin
    if (rst) begin
      bus_if.tx_busy <= 1'b0;
      busy_cnt       <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) bus_if.tx_busy <= 1'b0;
    end else if (bus_if.tx_start && !bus_if.tx_busy) begin
      tx_q.push_back(bus_if.tx_data);
      bus_if.tx_busy <= 1'b1;
      busy_cnt       <= 4;
    end
  end

  always @(negedge clk) begin
    if (out_valid) out_q.push_back(out_byte);
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] pw, input logic [15:0] sb,
                          input logic [15:0] sw, input logic [31:0] ob);
    @(negedge clk);
    prog_words = pw;
    sld_base   = sb;
    sld_words  = sw;
    out_bytes  = ob;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus_if.rx_ready = 1'b0;
    bus_if.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", bus_if.tx_start); end
    checks++; if (bus_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", bus_if.tx_data); end
    checks++; if (bus_if.src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd got=%b exp=0", bus_if.src_rd); end
    checks++; if (bus_if.src_addr !== 16'h0000) begin errors++; $display("FAIL reset_src_addr got=%h exp=0000", bus_if.src_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got=%h exp=00", out_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait99_filter();
    do_start(16'd2, 16'h0100, 16'd2, 32'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    send_rx(8'h55);
    repeat (20) @(negedge clk);
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL wait99_no_tx got=%0d bytes exp=0", tx_q.size()); end
  endtask

  task automatic test_prog();
    logic [7:0] exp [12] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  got;
    logic [15:0] ga;
    bit ok;
    send_rx(8'h99);
    wait_tx(12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prog_tx_count got=%0d exp=12", tx_q.size()); end
    for (int i = 0; i < 12; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL prog_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      ga = (i < rd_log.size()) ? rd_log[i] : 16'hxxxx;
      checks++; if (ga !== 16'(i)) begin errors++; $display("FAIL prog_addr%0d got=%h exp=%h", i, ga, 16'(i)); end
    end
  endtask

  task automatic test_sld();
    logic [7:0] exp [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hD8, 8'hC7, 8'hB6, 8'hA5};
    logic [15:0] expa [2] = '{16'h0100, 16'h0101};
    logic [7:0]  got;
    logic [15:0] ga;
    bit ok;
    repeat (10) @(negedge clk);
    send_rx(8'haa);
    wait_tx(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sld_tx_count got=%0d exp=20", tx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (12 + i < tx_q.size()) ? tx_q[12 + i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL sld_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      ga = (2 + i < rd_log.size()) ? rd_log[2 + i] : 16'hxxxx;
      checks++; if (ga !== expa[i]) begin errors++; $display("FAIL sld_addr%0d got=%h exp=%h", i, ga, expa[i]); end
    end
  endtask

  task automatic test_recv();
    logic [7:0] exp [3] = '{8'h31, 8'h32, 8'h0A};
    logic [7:0] got;
    repeat (10) @(negedge clk);
    send_rx(8'h31);
    send_rx(8'h32);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL recv_done_early got=%b exp=0", done); end
    send_rx(8'h0A);
    repeat (2) @(negedge clk);
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL recv_pulses got=%0d exp=3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < out_q.size()) ? out_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL recv_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL recv_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL recv_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [8] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    logic [7:0] got;
    bit ok;
    tx_q.delete(); rd_log.delete(); out_q.delete();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    do_start(16'd2, 16'h0000, 16'd0, 32'd0);
    send_rx(8'h99);
    wait_tx(7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_prog got=%0d exp=7", tx_q.size()); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start got=%b exp=0", bus_if.tx_start); end
    checks++; if (bus_if.src_rd !== 1'b0) begin errors++; $display("FAIL mid_src_rd got=%b exp=0", bus_if.src_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tx_q.delete(); rd_log.delete(); out_q.delete();
    do_start(16'd1, 16'h0000, 16'd0, 32'd0);
    send_rx(8'h99);
    wait_tx(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fresh_tx_count got=%0d exp=8", tx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL fresh_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    repeat (10) @(negedge clk);
    send_rx(8'haa);
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fresh_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fresh_busy got=%b exp=0", busy); end
    checks++; if (tx_q.size() != 8) begin errors++; $display("FAIL fresh_no_sld got=%0d exp=8", tx_q.size()); end
  endtask

  task automatic test_timeout();
    int k;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    do_start(16'd1, 16'h0000, 16'd0, 32'd1);
`ifdef HOST_LOADER_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (error === 1'b1) begin
        k = i;
        break;
      end
    end
    checks++; if (k != 100) begin errors++; $display("FAIL timeout_cycle got=%0d exp=100", k); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
`else
    k = 0;
    repeat (300) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL notimeout_busy got=%b exp=1", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL notimeout_error got=%b exp=0", error); end
`endif
  endtask

  initial begin
    test_reset();
    test_wait99_filter();
    test_prog();
    test_sld();
    test_recv();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd50_000_000, the handshake-wait watchdog limit in clk cycles.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that begins a load session.
REQ-005 SHALL have port prog_words, input, 16, the word count of the program section; sampled on start.
REQ-006 SHALL have port sld_base, input, 16, the source word address of the sld section; sampled on start.
REQ-007 SHALL have port sld_words, input, 16, the word count of the sld section; sampled on start.
REQ-008 SHALL have port out_bytes, input, 32, the number of result bytes expected; sampled on start.
REQ-009 SHALL have port src_addr, output, 16, the source memory word address.
REQ-010 SHALL have port src_rd, output, 1, the source read request.
REQ-011 SHALL have port src_data, input, 32, the source read data.
REQ-012 SHALL have port src_valid, input, 1, qualifying src_data.
REQ-013 SHALL have port tx_data, output, 8, the byte to the uart_tx instance.
REQ-014 SHALL have port tx_start, output, 1, the uart_tx start request.
REQ-015 SHALL have port tx_busy, input, 1, from uart_tx.
REQ-016 SHALL have port rx_data, input, 8, from uart_rx.
REQ-017 SHALL have port rx_ready, input, 1, the level from uart_rx.
REQ-018 SHALL have port out_byte, output, 8, the received result byte.
REQ-019 SHALL have port out_valid, output, 1, a one-cycle strobe for out_byte.
REQ-020 SHALL have port busy, output, 1, high from start until DONE or ERROR.
REQ-021 SHALL have port done, output, 1, sticky; set on reaching DONE.
REQ-022 SHALL have port error, output, 1, sticky; set on reaching ERROR.

Function
REQ-023 SHALL use the FSM states IDLE, WAIT99, HDR, PROG, WAITAA, SLD, RECV, DONE, ERROR.
REQ-024 IDLE SHALL go to WAIT99 on start; start SHALL be ignored in every other state.
REQ-025 Byte receive SHALL capture rx_data on the first cycle rx_ready is high, then ignore rx_ready until it has been low for at least one cycle.
REQ-026 Byte send: SHALL drive tx_data, then hold tx_start=1 until tx_busy=1, then drop tx_start and wait for tx_busy=0; the next byte SHALL NOT start earlier.
REQ-027 WAIT99 SHALL go to HDR on receiving byte 8'h99 and SHALL silently discard any other byte.
REQ-028 HDR SHALL send {prog_words,2'b00} zero-extended to 32 bits, as 4 bytes LSB first.
REQ-029 PROG SHALL, for i=0..prog_words-1: pulse src_rd for one cycle with src_addr=i, latch src_data on src_valid, then send 4 bytes LSB first.
REQ-030 prog_words=0 SHALL skip PROG and go directly to WAITAA.
REQ-031 WAITAA SHALL go to SLD on byte 8'haa and discard any other byte.
REQ-032 SLD SHALL behave as PROG with src_addr=sld_base+i (16-bit wrap), i=0..sld_words-1, words sent verbatim.
REQ-033 sld_words=0 SHALL skip SLD.
REQ-034 RECV SHALL present each received byte on out_byte with out_valid=1 for exactly one cycle.
REQ-035 RECV SHALL go to DONE when the received byte count equals out_bytes; out_bytes=0 SHALL go to DONE immediately.
REQ-036 A rx byte arriving during HDR, PROG or SLD SHALL be dropped without a state change.
REQ-037 DONE and ERROR SHALL hold until rst.

Reset
REQ-038 On rst=1 at a clk edge, the block SHALL enter IDLE with tx_start=0, tx_data=8'h00, src_rd=0, src_addr=0, out_valid=0, out_byte=0, busy=0, done=0, error=0, all counters 0.
REQ-039 rst SHALL abort a session mid-operation, including mid-byte; the uart instances are reset by the same signal.

Configuration
REQ-040 With macro HOST_LOADER_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT99, WAITAA, RECV and every tx_busy/src_valid wait, clearing on each state or byte advance, and SHALL force ERROR when it reaches TIMEOUT_CYCLES.
REQ-041 Without HOST_LOADER_TIMEOUT_EN, there SHALL be no counter, all waits SHALL be unbounded, and error SHALL stay constant 0.

Verification
REQ-042 SHALL cover: prog_words=2, src[0]=32'h00A00093, src[1]=32'hFFFFFFFF, core sends 99 -> TX bytes 08 00 00 00 93 00 A0 00 FF FF FF FF.
REQ-043 SHALL cover: bytes 55 then 99 received in WAIT99 -> 55 ignored, header starts only after 99.
REQ-044 SHALL cover: sld_base=16'h0100, sld_words=2, then AA received -> src_addr 0100, 0101 read, 8 bytes sent LSB first.
REQ-045 SHALL cover: out_bytes=3, rx bytes 31 32 0A -> three out_valid pulses carrying those values, then done=1, busy=0.
REQ-046 SHALL cover: rst asserted during PROG byte 2 -> next cycle IDLE, tx_start=0, src_rd=0, a fresh start behaves normally.
REQ-047 SHALL cover, with HOST_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: no 99 received -> error=1 at cycle 100 after start; without the macro, busy stays high.
